blk_rd_seq: RTL and testbench
=============================

BLK_RD_SEQ -- requirements
Module: blk_rd_seq

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, sets the RAM address width.
REQ-002 Parameter DATA_WIDTH, default 16, sets the RAM and stream data width.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  block-read request, sampled only in IDLE.
REQ-006 base_addr  in  ADDR_WIDTH  first RAM address of the block, sampled with start.
REQ-007 length  in  ADDR_WIDTH+1  word count 0..2**ADDR_WIDTH, sampled with start.
REQ-008 rdaddress  out  ADDR_WIDTH  read address to the synchronous-read RAM; registered.
REQ-009 q  in  DATA_WIDTH  RAM read data, valid exactly one clock edge after rdaddress is presented.
REQ-010 dout  out  DATA_WIDTH  stream data, equal to the output-FIFO head.
REQ-011 dout_valid  out  1  dout holds a valid word.
REQ-012 dout_ready  in  1  consumer accepts; a transfer occurs when dout_valid and dout_ready are both high at an edge.
REQ-013 dout_last  out  1  high with the final word of the block.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse when the block is complete.

Function
REQ-016 The FSM SHALL have three states, IDLE, READ and DRAIN, encoded as registered state.
REQ-017 In IDLE with start=1 and length>0, the block SHALL latch base_addr and length, load rdaddress=base_addr, and go to READ.
REQ-018 In IDLE with start=1 and length=0, the block SHALL stay in IDLE, pulse done in the next cycle, and emit no word.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 A read SHALL be issued on an edge only in READ, with remaining>0 and credit>0, where credit = 2 - fifo_count - inflight + (transfer at this edge).
REQ-021 Each issued read SHALL increment rdaddress modulo 2**ADDR_WIDTH, so 2**ADDR_WIDTH-1 wraps to 0, and SHALL decrement remaining.
REQ-022 inflight (0/1) SHALL be set by an issued read; q SHALL be written into the FIFO on the following edge.
REQ-023 The output FIFO SHALL be 2 entries deep, and neither overflow nor an idle read SHALL be possible given REQ-020.
REQ-024 A simultaneous FIFO write and transfer SHALL keep fifo_count unchanged and preserve order.
REQ-025 READ SHALL go to DRAIN on the edge that issues the last read.
REQ-026 DRAIN SHALL go to IDLE on the edge where the last word transfers; done SHALL be high in the following cycle.
REQ-027 dout_last SHALL be high only while the FIFO head is the block's final word.
REQ-028 With dout_ready held high, sustained throughput SHALL be 1 word per cycle.
REQ-029 First-word latency: start sampled at edge E0, first read at E1, q captured at E2, dout_valid high after E2.
REQ-030 dout and dout_last SHALL hold stable while dout_valid=1 and dout_ready=0.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, with rdaddress=0, fifo_count=0, inflight=0, remaining=0, dout=0, dout_valid=0, dout_last=0, busy=0 and done=0.
REQ-032 Reset mid-block SHALL discard all buffered and in-flight data; no word SHALL be emitted for the aborted block after release.
REQ-033 Outputs SHALL leave their reset values no earlier than the first rising edge after reset_n deasserts.

Verification
REQ-034 RAM preloaded with mem[a]=a; start, base=0x10, length=4, ready=1 -> dout 0x10,0x11,0x12,0x13 on consecutive cycles, last on 0x13, done 1 cycle after.
REQ-035 base=0xFE, length=4 -> dout 0xFE,0xFF,0x00,0x01 (address wrap).
REQ-036 length=6, ready toggling 1/0 randomly -> exactly 6 ordered words, none dropped or duplicated, dout stable while stalled, rdaddress never more than 2 ahead of the consumer.
REQ-037 length=0 -> no dout_valid, done pulse in the cycle after start, busy stays 0.
REQ-038 Second start while busy -> ignored; the block completes with the original length.
REQ-039 reset_n=0 after 2 of 8 words, then a new block of base 0x40, length 2 -> only 0x40,0x41 are emitted.

Source files
------------

// File: rtl/blk_rd_seq.sv
// Block read sequencer: streams a contiguous block out of a synchronous-read RAM
// through a 2-entry output FIFO under ready/valid backpressure.
module blk_rd_seq #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);

  state_t                  r_state;
  logic [ADDR_WIDTH:0]     r_remaining;
  logic                    r_inflight;
  logic                    r_inflight_last;
  logic [DATA_WIDTH-1:0]   r_head, r_tail;
  logic                    r_head_last, r_tail_last;
  logic [1:0]              r_count;
  logic                    r_done;

  logic w_xfer;
  logic w_issue;

  assign dout       = r_head;
  assign dout_valid = (r_count != 2'd0);
  assign dout_last  = dout_valid & r_head_last;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

  assign w_xfer = dout_valid & dout_ready;
  // Only issue while the FIFO slots not yet spoken for (after this edge's pop) can absorb the reply.
  assign w_issue = (r_state == READ) && (r_remaining != '0) &&
                   (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_xfer}));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      rdaddress       <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_head          <= '0;
      r_tail          <= '0;
      r_head_last     <= 1'b0;
      r_tail_last     <= 1'b0;
      r_count         <= 2'd0;
      r_done          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              rdaddress   <= base_addr;
              r_remaining <= length;
              r_state     <= READ;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        READ: begin
          if (w_issue && r_remaining == REM_ONE) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_xfer && r_head_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_issue) begin
        rdaddress   <= rdaddress + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_remaining == REM_ONE);

      // Two-register FIFO: head feeds dout directly, tail only holds the second word.
      case ({r_inflight, w_xfer})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head      <= q;
            r_head_last <= r_inflight_last;
          end else begin
            r_tail      <= q;
            r_tail_last <= r_inflight_last;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head      <= r_tail;
          r_head_last <= (r_count == 2'd2) & r_tail_last;
          r_count     <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head      <= q;
            r_head_last <= r_inflight_last;
          end else begin
            r_head      <= r_tail;
            r_head_last <= r_tail_last;
            r_tail      <= q;
            r_tail_last <= r_inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blk_rd_seq.sv
// Directed bench for blk_rd_seq with a mem[a]=a synchronous RAM model.
module tb_blk_rd_seq;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          dout_last;
  logic          busy;
  logic          done;

  blk_rd_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .rdaddress(rdaddress), .q(q), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) q <= DW'(rdaddress);

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clock) cyc++;

  logic rdy_rand = 1'b0;
  always @(posedge clock) begin
    #1;
    dout_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Transfer / status recorder, sampled mid-cycle
  logic [DW-1:0] xq[$];
  logic          lq[$];
  int            cq[$];
  int            dq[$];
  logic          busy_seen, valid_seen, p_stall, p_last;
  logic [DW-1:0] p_dout;
  logic [AW-1:0] blk_base = '0;
  int            stall_err, max_ahead, ahead;

  always @(negedge clock) begin
    if (reset_n) begin
      if (busy) begin
        ahead = int'(8'(rdaddress - blk_base)) - xq.size();
        if (ahead > max_ahead) max_ahead = ahead;
      end
      if (p_stall && (!dout_valid || dout != p_dout || dout_last != p_last)) stall_err++;
      p_stall = dout_valid && !dout_ready;
      p_dout  = dout;
      p_last  = dout_last;
      if (dout_valid && dout_ready) begin
        xq.push_back(dout);
        lq.push_back(dout_last);
        cq.push_back(cyc);
      end
      if (done) dq.push_back(cyc);
      if (busy) busy_seen = 1'b1;
      if (dout_valid) valid_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_rec();
    xq.delete(); lq.delete(); cq.delete(); dq.delete();
    busy_seen = 1'b0; valid_seen = 1'b0; p_stall = 1'b0;
    stall_err = 0; max_ahead = 0;
  endtask

  function automatic logic [31:0] xw(int i);
    return (i < xq.size()) ? 32'(xq[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] lw(int i);
    return (i < lq.size()) ? 32'(lq[i]) : 32'hDEAD;
  endfunction

  // Issue a block; optionally pulse a second start two cycles later while busy.
  task automatic run_block(input logic [AW-1:0] b, input logic [AW:0] n,
                           input bit intrude, output int s);
    bit ok;
    @(posedge clock); #2;
    clear_rec();
    blk_base  = b;
    start     = 1'b1;
    base_addr = b;
    length    = n;
    s         = cyc;
    @(posedge clock); #2;
    start = 1'b0;
    if (intrude) begin
      @(posedge clock); #2;
      start = 1'b1; base_addr = 8'h80; length = 9'd2;
      @(posedge clock); #2;
      start = 1'b0;
    end
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clock); #2;
      if (dq.size() != 0) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clock);
    #2;
  endtask

  int s;
  int nl;
  logic [7:0] wrap_exp [4];
  bit got2;

  initial begin
    wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
    clear_rec();
    #1;
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_addr",  32'(rdaddress), 32'd0);
    chk("rst_dout",  32'(dout), 32'd0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    // Basic block, full throughput
    run_block(8'h10, 9'd4, 1'b0, s);
    chk("b1_count", 32'(xq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("b1_word%0d", i), xw(i), 32'h10 + 32'(i));
    nl = 0;
    foreach (lq[i]) nl += int'(lq[i]);
    chk("b1_nlast", 32'(nl), 32'd1);
    chk("b1_last3", lw(3), 32'd1);
    chk("b1_latency", (cq.size() > 0) ? 32'(cq[0] - s) : 32'hDEAD, 32'd3);
    chk("b1_consec", (cq.size() == 4) ? 32'(cq[3] - cq[0]) : 32'hDEAD, 32'd3);
    chk("b1_ndone", 32'(dq.size()), 32'd1);
    chk("b1_done_cyc", (dq.size() > 0 && cq.size() == 4) ? 32'(dq[0] - cq[3]) : 32'hDEAD, 32'd1);

    // Address wrap
    run_block(8'hFE, 9'd4, 1'b0, s);
    chk("wrap_count", 32'(xq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_word%0d", i), xw(i), 32'(wrap_exp[i]));
    chk("wrap_last3", lw(3), 32'd1);

    // Random backpressure
    rdy_rand = 1'b1;
    run_block(8'h30, 9'd6, 1'b0, s);
    rdy_rand = 1'b0;
    chk("bp_count", 32'(xq.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_word%0d", i), xw(i), 32'h30 + 32'(i));
    chk("bp_last5", lw(5), 32'd1);
    chk("bp_stall_err", 32'(stall_err), 32'd0);
    chk("bp_ahead_le2", 32'(max_ahead <= 2), 32'd1);

    // Zero length
    run_block(8'h55, 9'd0, 1'b0, s);
    chk("z_valid_seen", 32'(valid_seen), 32'd0);
    chk("z_busy_seen", 32'(busy_seen), 32'd0);
    chk("z_ndone", 32'(dq.size()), 32'd1);
    chk("z_done_cyc", (dq.size() > 0) ? 32'(dq[0] - s) : 32'hDEAD, 32'd1);

    // Start while busy is ignored
    run_block(8'h20, 9'd5, 1'b1, s);
    chk("ib_count", 32'(xq.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("ib_word%0d", i), xw(i), 32'h20 + 32'(i));
    chk("ib_last4", lw(4), 32'd1);
    chk("ib_ndone", 32'(dq.size()), 32'd1);

    // Reset mid-block
    @(posedge clock); #2;
    clear_rec();
    blk_base = 8'h60; start = 1'b1; base_addr = 8'h60; length = 9'd8;
    @(posedge clock); #2;
    start = 1'b0;
    got2 = 1'b0;
    for (int k = 0; k < 100 && !got2; k++) begin
      @(posedge clock); #2;
      if (xq.size() >= 2) got2 = 1'b1;
    end
    chk("mr_two_words", 32'(got2), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mr_valid", 32'(dout_valid), 32'd0);
    chk("mr_busy",  32'(busy), 32'd0);
    chk("mr_addr",  32'(rdaddress), 32'd0);
    chk("mr_dout",  32'(dout), 32'd0);
    chk("mr_last",  32'(dout_last), 32'd0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    run_block(8'h40, 9'd2, 1'b0, s);
    chk("mr_count", 32'(xq.size()), 32'd2);
    chk("mr_word0", xw(0), 32'h40);
    chk("mr_word1", xw(1), 32'h41);
    chk("mr_last1", lw(1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
